// File: rtl/ai_exec_responder.sv
// Multi-cycle AI execute responder on the EX-stage start/busy/done handshake.
// Dot/MAC walk one packed signed lane per cycle; activations finish in one.
module ai_exec_responder #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_rd
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = 2 * LANE_W;

  localparam logic [2:0] OP_DOT  = 3'b000;
  localparam logic [2:0] OP_MAC  = 3'b001;
  localparam logic [2:0] OP_RELU = 3'b010;
  localparam logic [2:0] OP_HSIG = 3'b011;
  localparam logic [2:0] OP_STEP = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [4:0]        r_rd;
  logic [CW-1:0]     r_cnt;
  logic [ACC_W-1:0]  r_psum;
  logic [ACC_W-1:0]  r_acc;

  logic              w_accept;
  logic              w_iter;
  logic              w_last;
  logic [LANE_W-1:0] w_al;
  logic [LANE_W-1:0] w_bl;
  logic signed [PW-1:0] w_prod16;
  logic [ACC_W-1:0]  w_prod;
  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_acc_sum;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_shr;
  logic [31:0]       w_single;

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_iter    = (req_opcode == OP_DOT) ||
                     (req_opcode == OP_MAC);
  assign w_last    = (r_cnt == CW'(LANES - 1));

  assign w_al      = r_a[r_cnt*LANE_W +: LANE_W];
  assign w_bl      = r_b[r_cnt*LANE_W +: LANE_W];
  assign w_prod16  = $signed(w_al) * $signed(w_bl);
  assign w_prod    = {{(ACC_W-PW){w_prod16[PW-1]}}, w_prod16};
  assign w_sum     = r_psum + w_prod;
  assign w_acc_sum = r_acc + w_sum;

  assign w_sa      = req_a;
  assign w_shr     = w_sa >>> 2;

  // Single-cycle activation result, taken straight from the request.
  always_comb begin
    w_single = '0;
    case (req_opcode)
      OP_RELU: w_single = req_a[31] ? 32'd0 : req_a;
      OP_STEP: w_single = {31'd0, ~req_a[31]};
      OP_HSIG: begin
        if (w_sa <= -32'sd131072)
          w_single = 32'd0;
        else if (w_sa >= 32'sd131072)
          w_single = 32'h0001_0000;
        else
          w_single = w_shr + 32'h0000_8000;
      end
      default: w_single = 32'd0;
    endcase
  end

  // Control FSM, lane iteration, accumulator and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_psum      <= '0;
      r_acc       <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_rd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          resp_valid <= 1'b0;
          if (w_accept) begin
            r_op <= req_opcode;
            r_a  <= req_a;
            r_b  <= req_b;
            r_rd <= req_rd;
            if (w_iter) begin
              r_cnt   <= '0;
              r_psum  <= '0;
              r_state <= S_COMPUTE;
            end else begin
              resp_result <= w_single;
              resp_rd     <= req_rd;
              resp_valid  <= 1'b1;
              if (req_opcode == OP_CLR)
                r_acc <= '0;
              r_state <= S_RESP;
            end
          end
        end
        S_COMPUTE: begin
          r_psum <= w_sum;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            resp_valid <= 1'b1;
            resp_rd    <= r_rd;
            if (r_op == OP_MAC) begin
              r_acc       <= w_acc_sum;
              resp_result <= w_acc_sum;
            end else begin
              resp_result <= w_sum;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ai_exec_responder.sv
// Bench for ai_exec_responder: directed vector table, reset-abort
// sequences and randomized ops against a lane-arithmetic model.
module tb_ai_exec_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic [4:0]  resp_rd;

  int cmp = 0;
  int bad = 0;
  int m_acc = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  ai_exec_responder dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rd      (req_rd),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_rd     (resp_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: signed lane dot product, Q16.16 hard sigmoid, etc.
  function automatic logic [31:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int s;
    int sa;
    int t;
    byte la;
    byte lb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      la = a[i*8 +: 8];
      lb = b[i*8 +: 8];
      s = s + int'(la) * int'(lb);
    end
    sa = a;
    case (op)
      3'd0: return s;
      3'd1: begin
        m_acc = m_acc + s;
        return m_acc;
      end
      3'd2: return (sa < 0) ? 32'd0 : a;
      3'd3: begin
        if (sa <= -131072) return 32'd0;
        if (sa >= 131072) return 32'h0001_0000;
        t = sa >>> 2;
        return t + 32'h0000_8000;
      end
      3'd4: return (sa < 0) ? 32'd0 : 32'd1;
      3'd5: begin
        m_acc = 0;
        return 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic run_op(input string nm, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int lat;
    int bnd;
    bnd = 0;
    while (!req_ready && bnd < 20) begin
      @(negedge clk);
      bnd++;
    end
    chk($sformatf("%s ready", nm), 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_rd     = rd;
    @(negedge clk);
    lat = 1;
    chk($sformatf("%s busy", nm), 32'(busy), 32'd1);
    req_opcode = 3'b010;
    req_a      = 32'h0000_1234;
    req_rd     = ~rd;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    chk($sformatf("%s latency", nm), lat, (op <= 3'd1) ? 5 : 1);
    chk($sformatf("%s result", nm), resp_result, exp);
    chk($sformatf("%s rd", nm), 32'(resp_rd), 32'(rd));
    @(negedge clk);
    chk($sformatf("%s strobe", nm), 32'(resp_valid), 32'd0);
    chk($sformatf("%s hold", nm), resp_result, exp);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk($sformatf("%s busy", nm), 32'(busy), 32'd0);
    chk($sformatf("%s valid", nm), 32'(resp_valid), 32'd0);
    chk($sformatf("%s result", nm), resp_result, 32'd0);
    chk($sformatf("%s rd", nm), 32'(resp_rd), 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    logic [4:0]  rd;
    logic [31:0] edges [6];
    bit          seen;

    edges[0] = 32'hFFFE_0000;
    edges[1] = 32'h0002_0000;
    edges[2] = 32'h8000_0000;
    edges[3] = 32'h7FFF_FFFF;
    edges[4] = 32'hFFFE_0001;
    edges[5] = 32'h0001_FFFF;

    tbl.push_back('{3'd0, 32'h0102_0304, 32'h0101_0101, 5'd3,  32'd10});
    tbl.push_back('{3'd0, 32'hFF02_FF02, 32'h7F7F_7F7F, 5'd4,  32'd254});
    tbl.push_back('{3'd0, 32'h8080_8080, 32'h8080_8080, 5'd5,  32'h0001_0000});
    tbl.push_back('{3'd5, 32'd0,         32'd0,         5'd6,  32'd0});
    tbl.push_back('{3'd1, 32'h0102_0304, 32'h0101_0101, 5'd7,  32'd10});
    tbl.push_back('{3'd1, 32'h0102_0304, 32'h0101_0101, 5'd8,  32'd20});
    tbl.push_back('{3'd5, 32'd0,         32'd0,         5'd9,  32'd0});
    tbl.push_back('{3'd1, 32'h0102_0304, 32'h0101_0101, 5'd10, 32'd10});
    tbl.push_back('{3'd6, 32'hFFFF_FFFF, 32'd0,         5'd11, 32'd0});
    tbl.push_back('{3'd1, 32'h0102_0304, 32'h0101_0101, 5'd12, 32'd20});
    tbl.push_back('{3'd2, 32'h8000_0000, 32'd0,         5'd13, 32'd0});
    tbl.push_back('{3'd2, 32'd5,         32'd0,         5'd14, 32'd5});
    tbl.push_back('{3'd4, 32'hFFFF_FFFF, 32'd0,         5'd15, 32'd0});
    tbl.push_back('{3'd4, 32'd0,         32'd0,         5'd16, 32'd1});
    tbl.push_back('{3'd3, 32'h0004_0000, 32'd0,         5'd17, 32'h0001_0000});
    tbl.push_back('{3'd3, 32'hFFFC_0000, 32'd0,         5'd18, 32'd0});
    tbl.push_back('{3'd3, 32'h0000_0000, 32'd0,         5'd19, 32'h0000_8000});
    tbl.push_back('{3'd3, 32'h0001_0000, 32'd0,         5'd20, 32'h0000_C000});
    tbl.push_back('{3'd3, 32'hFFFE_0000, 32'd0,         5'd21, 32'd0});
    tbl.push_back('{3'd3, 32'hFFFE_0001, 32'd0,         5'd22, 32'd0});
    tbl.push_back('{3'd3, 32'h0001_FFFF, 32'd0,         5'd23, 32'h0000_FFFF});

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_rd     = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd1);

    foreach (tbl[i]) begin
      e = model(tbl[i].op, tbl[i].a, tbl[i].b);
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a,
             tbl[i].b, tbl[i].rd, tbl[i].exp);
    end

    // Abort a MAC in its second COMPUTE cycle, with a request ignored.
    e = model(3'd1, 32'h0102_0304, 32'h0101_0101);
    req_valid  = 1'b1;
    req_opcode = 3'd1;
    req_a      = 32'h0102_0304;
    req_b      = 32'h0101_0101;
    req_rd     = 5'd25;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd1);
    req_opcode = 3'd2;
    req_a      = 32'd77;
    req_rd     = 5'd26;
    @(negedge clk);
    chk("abort still busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    chk("abort ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    m_acc = 0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    chk("abort no resp", 32'(seen), 32'd0);
    e = model(3'd1, 32'h0102_0304, 32'h0101_0101);
    run_op("post abort mac", 3'd1, 32'h0102_0304,
           32'h0101_0101, 5'd27, e);

    // Reset landing on the RESP cycle must also clear the accumulator.
    req_valid  = 1'b1;
    req_opcode = 3'd2;
    req_a      = 32'd5;
    req_rd     = 5'd28;
    @(negedge clk);
    req_valid = 1'b0;
    chk("resp abort valid", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("resp abort");
    m_acc = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    e = model(3'd1, 32'h0102_0304, 32'h0101_0101);
    run_op("post resp abort mac", 3'd1, 32'h0102_0304,
           32'h0101_0101, 5'd29, e);

    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      if ($urandom_range(0, 3) == 0)
        a = edges[$urandom_range(0, 5)];
      e = model(op, a, b);
      run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, rd, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
